// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg
//   Shared KGP-RISC decode definitions: opcode encodings, the branch-and-link
//   function code, the link register index and the decoded_t record that the
//   decode stage produces and buffers.
//   decoded_t imm/label fields are KGP_XLEN wide. Modules that carry decoded_t
//   must be built with XLEN equal to KGP_XLEN.
package kgp_risc_pkg;

   localparam int KGP_XLEN = 32;

   localparam logic [2:0] OP_R  = 3'b000;
   localparam logic [2:0] OP_I  = 3'b001;
   localparam logic [2:0] OP_LS = 3'b010;
   localparam logic [2:0] OP_B1 = 3'b011;
   localparam logic [2:0] OP_B2 = 3'b100;
   localparam logic [2:0] OP_B3 = 3'b101;

   localparam logic [3:0] FUNC_BL  = 4'b0001;
   localparam logic [4:0] LINK_REG = 5'd31;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [3:0]          func_code;
      logic [4:0]          rs;
      logic [4:0]          rt;
      logic                rs_used;
      logic                rt_used;
      logic [KGP_XLEN-1:0] imm;
      logic [KGP_XLEN-1:0] label;
      logic                illegal;
   } decoded_t;

endpackage

// File: rtl/kgp_instr_fields.sv
// kgp_instr_fields
//   Purely combinational field extractor: {instruction, pc} -> decoded_t.
//   Every field not defined by the instruction's format is driven to 0.
// Ports
//   instruction  in   32    raw instruction word
//   pc           in   PC_W  PC of that instruction (used only for bl link value)
//   dec          out  decoded_t  decoded fields
module kgp_instr_fields
   import kgp_risc_pkg::*;
#(
   parameter int XLEN = KGP_XLEN,
   parameter int PC_W = 32
) (
   input  logic [31:0]   instruction,
   input  logic [PC_W-1:0] pc,
   output decoded_t      dec
);

   always_comb begin
      dec        = '0;
      dec.opcode = instruction[31:29];
      case (instruction[31:29])
         OP_R: begin
            dec.rs        = instruction[28:24];
            dec.rt        = instruction[23:19];
            dec.imm       = {{(XLEN-5){1'b0}}, instruction[18:14]};
            dec.func_code = instruction[13:10];
            dec.rs_used   = 1'b1;
            dec.rt_used   = 1'b1;
         end
         OP_I: begin
            dec.rs        = instruction[28:24];
            dec.imm       = {{(XLEN-20){instruction[23]}}, instruction[23:4]};
            dec.func_code = instruction[3:0];
            dec.rs_used   = 1'b1;
         end
         OP_LS: begin
            dec.rs        = instruction[28:24];
            dec.rt        = instruction[23:19];
            dec.imm       = {{(XLEN-18){instruction[18]}}, instruction[18:1]};
            dec.func_code = {3'b000, instruction[0]};
            dec.rs_used   = 1'b1;
            dec.rt_used   = 1'b1;
         end
         OP_B1: begin
            dec.label     = {{(XLEN-25){1'b0}}, instruction[28:4]};
            dec.func_code = instruction[3:0];
            // bl is recognised from the incoming word itself
            if (instruction[3:0] == FUNC_BL) begin
               dec.rt      = LINK_REG;
               dec.rt_used = 1'b1;
               dec.imm     = XLEN'(pc) + XLEN'(1);
            end
         end
         OP_B2: begin
            dec.rs        = instruction[28:24];
            dec.func_code = instruction[23:20];
            dec.rs_used   = 1'b1;
         end
         OP_B3: begin
            dec.rs        = instruction[28:24];
            dec.label     = {{(XLEN-20){1'b0}}, instruction[23:4]};
            dec.func_code = instruction[3:0];
            dec.rs_used   = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/kgp_decode_stage.sv
// kgp_decode_stage
//   Decode stage between fetch and register-read. Decodes {instruction, pc}
//   on push and buffers the result in a DEPTH-entry FIFO presented downstream
//   with valid/ready. flush empties the FIFO at the next edge.
//   Optional feature macro: DECODE_PERF_CNT_EN adds saturating pop counters
//   perf_decoded / perf_illegal (cleared by reset only).
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   flush              synchronous flush, overrides push and pop
//   in_valid/in_ready  fetch handshake (in_ready = FIFO not full)
//   instruction, pc    incoming word and its PC
//   out_valid/out_ready downstream handshake on the FIFO head
//   opcode..illegal    decoded fields of the head entry
//   perf_decoded/perf_illegal  pop counters (DECODE_PERF_CNT_EN only)
module kgp_decode_stage
   import kgp_risc_pkg::*;
#(
   parameter int XLEN  = KGP_XLEN,
   parameter int PC_W  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic [PC_W-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      opcode,
   output logic [3:0]      func_code,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic            rs_used,
   output logic            rt_used,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] label,
   output logic            illegal
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]     perf_decoded,
   output logic [31:0]     perf_illegal
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   decoded_t      mem [DEPTH];
   decoded_t      dec;
   decoded_t      head;
   decoded_t      last_q;
   logic          push;
   logic          pop;

   kgp_instr_fields #(
      .XLEN (XLEN),
      .PC_W (PC_W)
   ) u_fields (
      .instruction (instruction),
      .pc          (pc),
      .dec         (dec)
   );

   assign in_ready  = (count != (AW+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dec;
   end

   // Copy of the most recently popped entry, shown while the FIFO is empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= '0;
      end else if (pop) begin
         last_q <= mem[rd_ptr];
      end
   end

   assign head = out_valid ? mem[rd_ptr] : last_q;

   assign opcode    = head.opcode;
   assign func_code = head.func_code;
   assign rs        = head.rs;
   assign rt        = head.rt;
   assign rs_used   = head.rs_used;
   assign rt_used   = head.rt_used;
   assign imm       = head.imm;
   assign label     = head.label;
   assign illegal   = head.illegal;

`ifdef DECODE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_decoded <= '0;
         perf_illegal <= '0;
      end else if (pop) begin
         if (head.illegal) begin
            if (perf_illegal != '1) perf_illegal <= perf_illegal + 1'b1;
         end else begin
            if (perf_decoded != '1) perf_decoded <= perf_decoded + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_kgp_decode_stage.sv
module tb_kgp_decode_stage;
   import kgp_risc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  opcode;
   logic [3:0]  func_code;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        rs_used;
   logic        rt_used;
   logic [31:0] imm;
   logic [31:0] label;
   logic        illegal;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0] perf_decoded;
   logic [31:0] perf_illegal;
`endif

   int checks = 0;
   int errors = 0;
   int exp_dec = 0;
   int exp_ill = 0;

   kgp_decode_stage #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
`ifdef DECODE_PERF_CNT_EN
      .perf_decoded (perf_decoded),
      .perf_illegal (perf_illegal),
`endif
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .pc          (pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .opcode      (opcode),
      .func_code   (func_code),
      .rs          (rs),
      .rt          (rt),
      .rs_used     (rs_used),
      .rt_used     (rt_used),
      .imm         (imm),
      .label       (label),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push one word into an empty FIFO with out_ready=1, check the head,
   // then check it has been consumed. Entered and left at posedge+1.
   task automatic do_vec(input string tag, input logic [31:0] ins, input logic [31:0] p,
                         input logic [2:0] eop, input logic [3:0] efn,
                         input logic [4:0] ers, input logic [4:0] ert,
                         input logic ersu, input logic ertu,
                         input logic [31:0] eimm, input logic [31:0] elab,
                         input logic eill);
      instruction = ins;
      pc          = p;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_valid"},   32'(out_valid), 32'd1);
      chk({tag, "_opcode"},  32'(opcode),    32'(eop));
      chk({tag, "_func"},    32'(func_code), 32'(efn));
      chk({tag, "_rs"},      32'(rs),        32'(ers));
      chk({tag, "_rt"},      32'(rt),        32'(ert));
      chk({tag, "_rs_used"}, 32'(rs_used),   32'(ersu));
      chk({tag, "_rt_used"}, 32'(rt_used),   32'(ertu));
      chk({tag, "_imm"},     imm,            eimm);
      chk({tag, "_label"},   label,          elab);
      chk({tag, "_illegal"}, 32'(illegal),   32'(eill));
      @(posedge clk); #1;
      if (eill) exp_ill++; else exp_dec++;
      chk({tag, "_popped"},  32'(out_valid), 32'd0);
`ifdef DECODE_PERF_CNT_EN
      chk({tag, "_perf_dec"}, perf_decoded, 32'(exp_dec));
      chk({tag, "_perf_ill"}, perf_illegal, 32'(exp_ill));
`endif
   endtask

   localparam logic [31:0] W_A = 32'h053FE800; // R  rs=5
   localparam logic [31:0] W_B = 32'hA1123457; // B3 rs=1
   localparam logic [31:0] W_C = 32'h89CABCDE; // B2 rs=9

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instruction = '0; pc = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_opcode",    32'(opcode),    32'd0);
      chk("rst_imm",       imm,            32'd0);
      chk("rst_illegal",   32'(illegal),   32'd0);

      out_ready = 1'b1;
      do_vec("i_fmt",  32'h23FFFFC0, 32'h0,    3'b001, 4'h0, 5'd3, 5'd0,  1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0);
      do_vec("bl",     32'h60000101, 32'h40,   3'b011, 4'h1, 5'd0, 5'd31, 1'b0, 1'b1, 32'h41, 32'h10, 1'b0);
      do_vec("ill7",   32'hE0000000, 32'h0,    3'b111, 4'h0, 5'd0, 5'd0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      do_vec("r_fmt",  W_A,          32'h0,    3'b000, 4'hA, 5'd5, 5'd7,  1'b1, 1'b1, 32'h1F, 32'h0, 1'b0);
      do_vec("ls_fmt", 32'h42240001, 32'h0,    3'b010, 4'h1, 5'd2, 5'd4,  1'b1, 1'b1, 32'hFFFE0000, 32'h0, 1'b0);
      do_vec("b2_fmt", W_C,          32'h0,    3'b100, 4'hC, 5'd9, 5'd0,  1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      do_vec("b3_fmt", W_B,          32'h0,    3'b101, 4'h7, 5'd1, 5'd0,  1'b1, 1'b0, 32'h0, 32'h12345, 1'b0);
      do_vec("b1_nbl", 32'h7FFFFFF2, 32'h1234, 3'b011, 4'h2, 5'd0, 5'd0,  1'b0, 1'b0, 32'h0, 32'h1FFFFFF, 1'b0);
      do_vec("ill6",   32'hDFFFFFFF, 32'h0,    3'b110, 4'h0, 5'd0, 5'd0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("hold_illegal", 32'(illegal), 32'd1);
      chk("hold_opcode",  32'(opcode),  32'd6);

      // backpressure: DEPTH=2 fills, third word waits
      out_ready = 1'b0;
      instruction = W_A; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready1", 32'(in_ready), 32'd1);
      instruction = W_B;
      @(posedge clk); #1;
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      chk("bp_full_valid", 32'(out_valid), 32'd1);
      chk("bp_head_a",     32'(opcode),   32'd0);
      instruction = W_C;
      @(posedge clk); #1;
      chk("bp_held_ready", 32'(in_ready), 32'd0);
      chk("bp_held_rs",    32'(rs),       32'd5);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_pop1_ready", 32'(in_ready), 32'd1);
      chk("bp_head_b",     32'(opcode),   32'd5);
      @(posedge clk); #1;
      chk("bp_head_c",     32'(opcode),   32'd4);
      chk("bp_head_c_rs",  32'(rs),       32'd9);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_empty",      32'(out_valid), 32'd0);
      chk("bp_hold_c",     32'(opcode),    32'd4);
      exp_dec += 3;

      // flush with a full FIFO and simultaneous push/pop
      out_ready = 1'b0;
      instruction = W_A; in_valid = 1'b1;
      @(posedge clk); #1;
      instruction = W_B;
      @(posedge clk); #1;
      chk("fl_full", 32'(in_ready), 32'd0);
      flush = 1'b1; out_ready = 1'b1; instruction = 32'h23FFFFC0;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_ready", 32'(in_ready),  32'd1);
      chk("fl_hold",  32'(opcode),    32'd4);
      @(posedge clk); #1;
      chk("fl_nopush", 32'(out_valid), 32'd0);
`ifdef DECODE_PERF_CNT_EN
      chk("fl_perf_dec", perf_decoded, 32'(exp_dec));
`endif

      // asynchronous reset with one entry queued
      out_ready = 1'b0;
      instruction = W_B; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("ar_queued", 32'(out_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("ar_valid",  32'(out_valid), 32'd0);
      chk("ar_ready",  32'(in_ready),  32'd1);
      chk("ar_opcode", 32'(opcode),    32'd0);
      chk("ar_rs",     32'(rs),        32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_dec = 0; exp_ill = 0;
      out_ready = 1'b1;
      do_vec("post_rst", 32'h23FFFFC0, 32'h0, 3'b001, 4'h0, 5'd3, 5'd0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
